// File: rtl/gen_gamma_pkg.sv
// Shared definitions for the gamma encoder/decoder pair.
package gen_gamma_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOADED = 2'd1,
      RUN    = 2'd2
   } gamma_state_t;

   // One gamma step: (g + k) mod 2^size. Operands are carried at 32 bits so
   // both ends of the link can share one function regardless of word width.
   function automatic logic [31:0] gamma_step(input logic [31:0] g,
                                              input logic [31:0] k,
                                              input int unsigned size);
      logic [31:0] mask;
      mask = (size >= 32) ? '1 : ((32'd1 << size) - 32'd1);
      return (g + k) & mask;
   endfunction

endpackage

// File: rtl/gen_gamma_core.sv
// Key and gamma registers with the step adder; load restarts the sequence
// at the seed, advance moves gamma one step along.
module gen_gamma_core
   import gen_gamma_pkg::*;
#(
   parameter int unsigned SIZE = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            advance,
   input  logic [SIZE-1:0] nk,
   output logic [SIZE-1:0] k,
   output logic [SIZE-1:0] g
);

   logic [SIZE-1:0] k_q, k_d;
   logic [SIZE-1:0] g_q, g_d;

   // Next key/gamma: load has priority over advance.
   always_comb begin
      k_d = k_q;
      g_d = g_q;
      if (load) begin
         k_d = nk;
         g_d = nk;
      end else if (advance) begin
         g_d = SIZE'(gamma_step(32'(g_q), 32'(k_q), SIZE));
      end
   end

   // Key/gamma state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_q <= '0;
         g_q <= '0;
      end else begin
         k_q <= k_d;
         g_q <= g_d;
      end
   end

   assign k = k_q;
   assign g = g_q;

endmodule

// File: rtl/gen_gamma_encoder.sv
// Additive gamma encoder: md = pd + gamma with carry kept, valid/ready on
// both sides, single output register.
module gen_gamma_encoder
   import gen_gamma_pkg::*;
#(
   parameter int unsigned SIZE = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            set0,
   input  logic            set1,
   input  logic [SIZE-1:0] nk,
   input  logic [SIZE-1:0] pd,
   input  logic            pd_valid,
   output logic            pd_ready,
   output logic [SIZE:0]   md,
   output logic            md_valid,
   input  logic            md_ready,
   output logic [SIZE-1:0] word_cnt,
   output logic            busy
);

   gamma_state_t    state_q, state_d;
   logic [SIZE:0]   md_q, md_d;
   logic            md_valid_q, md_valid_d;
   logic [SIZE-1:0] word_cnt_q, word_cnt_d;
   logic [SIZE-1:0] k_cur;
   logic [SIZE-1:0] g_cur;
   logic            accept;

   gen_gamma_core #(.SIZE(SIZE)) u_core (
      .clk     (clk),
      .rst     (rst),
      .load    (set0),
      .advance (accept),
      .nk      (nk),
      .k       (k_cur),
      .g       (g_cur)
   );

   // Input handshake: only in RUN, never during a key load, and only when
   // the output register is empty or draining this cycle.
   always_comb begin
      pd_ready = (state_q == RUN) && !set0 && (!md_valid_q || md_ready);
      accept   = pd_valid && pd_ready;
   end

   // Next state: set0 reloads from any state and wins over set1.
   always_comb begin
      state_d = state_q;
      if (set0) begin
         state_d = LOADED;
      end else begin
         case (state_q)
            IDLE:    state_d = IDLE;
            LOADED:  state_d = set1 ? RUN : LOADED;
            RUN:     state_d = set1 ? RUN : LOADED;
            default: state_d = IDLE;
         endcase
      end
   end

   // Output register, valid flag and word counter.
   always_comb begin
      md_d       = md_q;
      md_valid_d = md_valid_q;
      word_cnt_d = word_cnt_q;
      if (set0) begin
         md_valid_d = 1'b0;
         word_cnt_d = '0;
      end else if (accept) begin
         md_d       = {1'b0, pd} + {1'b0, g_cur};
         md_valid_d = 1'b1;
         word_cnt_d = word_cnt_q + SIZE'(1);
      end else if (md_valid_q && md_ready) begin
         md_valid_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         md_q       <= '0;
         md_valid_q <= 1'b0;
         word_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         md_q       <= md_d;
         md_valid_q <= md_valid_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   assign md       = md_q;
   assign md_valid = md_valid_q;
   assign word_cnt = word_cnt_q;
   assign busy     = (state_q == RUN);

endmodule
